// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: address window
// defaults, NOP encoding, fetch FSM encoding and a PC legality helper.
package instr_fetch_pkg;

    localparam int          INSTR_W             = 32;
    localparam logic [31:0] RESET_PC_DEF        = 32'h0000_3000;
    localparam logic [31:0] INSTR_MEM_BYTES_DEF = 32'h0000_1000;
    localparam logic [31:0] NOP                 = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_t;

    // A PC is usable when word aligned and inside [base, base+bytes).
    // The subtraction form avoids overflow when base+bytes reaches 2^32.
    function automatic logic pc_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] bytes);
        pc_legal = (addr[1:0] == 2'b00) && (addr >= base) && ((addr - base) < bytes);
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register. Data fields load together; the valid bit has
// its own write enable so a fetch can be squashed without touching data.
import instr_fetch_pkg::*;

module if_id_reg (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [31:0]         pc,
    input  logic                valid_we,
    input  logic                valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc_plus4,
    output logic                if_valid
);

    logic [INSTR_W-1:0] instr_reg;
    logic [31:0]        pc_reg;
    logic [31:0]        pc_plus4_reg;
    logic               valid_reg;

    // Capture fetched word and its PC on load; update valid independently.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_reg    <= NOP;
            pc_reg       <= 32'd0;
            pc_plus4_reg <= 32'd0;
            valid_reg    <= 1'b0;
        end else begin
            if (load) begin
                instr_reg    <= instr;
                pc_reg       <= pc;
                pc_plus4_reg <= pc + 32'd4;
            end
            if (valid_we) begin
                valid_reg <= valid;
            end
        end
    end

    assign if_instr    = instr_reg;
    assign if_pc       = pc_reg;
    assign if_pc_plus4 = pc_plus4_reg;
    assign if_valid    = valid_reg;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the architectural PC, drives the instruction memory
// address and fills the IF/ID register. Optional macro
// BRANCH_DELAY_SLOT_EN makes a redirect keep the in-flight word as a
// valid delay-slot instruction instead of squashing it.
import instr_fetch_pkg::*;

module instr_fetch #(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter logic [31:0] INSTR_MEM_BYTES = INSTR_MEM_BYTES_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                halt,
    output logic [31:0]         imem_pc,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc_plus4,
    output logic                if_valid,
    output logic                pc_fault,
    output logic                halted
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         fault_reg, fault_next;
    logic         ifid_load, ifid_valid_we, ifid_valid;
    logic [31:0]  seq_pc;

    assign seq_pc = pc_reg + 32'd4;

    // State, PC and sticky fault registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_PC;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            fault_reg <= fault_next;
        end
    end

    // Next PC / FSM / IF-ID control: halt > redirect > stall > sequential.
    // A candidate PC that fails the legality check leaves pc untouched.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        fault_next    = fault_reg;
        ifid_load     = 1'b0;
        ifid_valid_we = 1'b0;
        ifid_valid    = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (halt) begin
                    state_next    = ST_HALTED;
                    ifid_valid_we = 1'b1;
                end else if (redirect_valid && !(DELAY_SLOT && stall)) begin
                    // With delay slots the word at pc is the slot instruction.
                    ifid_load     = DELAY_SLOT;
                    ifid_valid_we = 1'b1;
                    if (pc_legal(redirect_pc, RESET_PC, INSTR_MEM_BYTES)) begin
                        pc_next    = redirect_pc;
                        ifid_valid = DELAY_SLOT;
                    end else begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_load     = 1'b1;
                    ifid_valid_we = 1'b1;
                    if (pc_legal(seq_pc, RESET_PC, INSTR_MEM_BYTES)) begin
                        pc_next    = seq_pc;
                        ifid_valid = 1'b1;
                    end else begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                    end
                end
            end
            default: begin
                // HALTED and FAULT are terminal until reset.
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clock       (clock),
        .reset       (reset),
        .load        (ifid_load),
        .instr       (imem_instr),
        .pc          (pc_reg),
        .valid_we    (ifid_valid_we),
        .valid       (ifid_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_valid    (if_valid)
    );

    assign imem_pc  = pc_reg;
    assign pc_fault = fault_reg;
    assign halted   = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed table, a window-end sequence and a
// randomized run, all checked against a behavioural model of the stage.
module tb_instr_fetch;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_pc, imem_instr, if_instr, if_pc, if_pc_plus4;
    logic        if_valid, pc_fault, halted;

    logic [31:0] mem [0:1023];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    assign imem_instr = mem[imem_pc[11:2]];

    instr_fetch dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid), .pc_fault(pc_fault), .halted(halted)
    );

    // Behavioural model: mode 0 = running, 1 = halted, 2 = faulted.
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifp4;
    logic        m_v, m_fault;
    int          m_mode;

    function automatic bit legal(input logic [31:0] a);
        longint v;
        v = longint'(a);
        return (v % 4 == 0) && (v >= 64'h3000) && (v < 64'h4000);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[(a - 32'h3000) / 4];
    endfunction

    task automatic model_step(input bit r, input bit s, input bit rv,
                              input logic [31:0] rpc, input bit h);
        logic [31:0] nxt;
        if (r) begin
            m_pc = 32'h3000; m_instr = 0; m_ifpc = 0; m_ifp4 = 0;
            m_v = 0; m_fault = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (h) begin
                m_mode = 1; m_v = 0;
            end else if (rv && !(DS && s)) begin
                if (DS) begin
                    m_instr = word_at(m_pc); m_ifpc = m_pc; m_ifp4 = m_pc + 4;
                end
                m_v = DS && legal(rpc);
                if (legal(rpc)) m_pc = rpc;
                else begin m_fault = 1; m_mode = 2; end
            end else if (!s) begin
                m_instr = word_at(m_pc); m_ifpc = m_pc; m_ifp4 = m_pc + 4;
                nxt = m_pc + 4;
                m_v = legal(nxt);
                if (legal(nxt)) m_pc = nxt;
                else begin m_fault = 1; m_mode = 2; end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("imem_pc", imem_pc, m_pc);
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ifpc);
        chk("if_pc_plus4", if_pc_plus4, m_ifp4);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
        chk("pc_fault", {31'd0, pc_fault}, {31'd0, m_fault});
        chk("halted", {31'd0, halted}, {31'd0, m_mode == 1});
    endtask

    // Drive one cycle of inputs, advance model at the edge, compare after.
    task automatic cycle(input bit r, input bit s, input bit rv,
                         input logic [31:0] rpc, input bit h);
        reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc; halt = h;
        @(posedge clock);
        model_step(r, s, rv, rpc, h);
        #1;
        chk_model();
    endtask

    typedef struct {
        bit          rst, stl, rv;
        logic [31:0] rpc;
        bit          hlt;
        logic [31:0] e_pc, e_ifpc;
        bit          e_v, e_fault, e_halt;
    } vec_t;

    vec_t vecs [17];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        //           rst stl rv rpc          hlt e_pc        e_ifpc                        v  f  h
        vecs[0]  = '{1, 0, 0, 32'h0,    0, 32'h3000, 32'h0,                       0, 0, 0};
        vecs[1]  = '{0, 0, 0, 32'h0,    0, 32'h3004, 32'h3000,                    1, 0, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,    0, 32'h3008, 32'h3004,                    1, 0, 0};
        vecs[3]  = '{0, 1, 0, 32'h0,    0, 32'h3008, 32'h3004,                    1, 0, 0};
        vecs[4]  = '{0, 1, 0, 32'h0,    0, 32'h3008, 32'h3004,                    1, 0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,    0, 32'h300C, 32'h3008,                    1, 0, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,    0, 32'h3010, 32'h300C,                    1, 0, 0};
        vecs[7]  = '{0, 0, 1, 32'h3100, 0, 32'h3100, DS ? 32'h3010 : 32'h300C,    DS, 0, 0};
        vecs[8]  = '{0, 0, 0, 32'h0,    0, 32'h3104, 32'h3100,                    1, 0, 0};
        vecs[9]  = '{0, 0, 1, 32'h3102, 0, 32'h3104, DS ? 32'h3104 : 32'h3100,    0, 1, 0};
        vecs[10] = '{0, 0, 0, 32'h0,    0, 32'h3104, DS ? 32'h3104 : 32'h3100,    0, 1, 0};
        vecs[11] = '{1, 0, 0, 32'h0,    0, 32'h3000, 32'h0,                       0, 0, 0};
        vecs[12] = '{0, 0, 1, 32'h4000, 0, 32'h3000, DS ? 32'h3000 : 32'h0,       0, 1, 0};
        vecs[13] = '{1, 0, 0, 32'h0,    0, 32'h3000, 32'h0,                       0, 0, 0};
        vecs[14] = '{0, 0, 1, 32'h3100, 1, 32'h3000, 32'h0,                       0, 0, 1};
        vecs[15] = '{0, 0, 0, 32'h0,    0, 32'h3000, 32'h0,                       0, 0, 1};
        vecs[16] = '{1, 1, 1, 32'h3100, 0, 32'h3000, 32'h0,                       0, 0, 0};

        @(negedge clock);
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rpc, vecs[i].hlt);
            chk($sformatf("vec%0d.imem_pc", i), imem_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d.if_pc", i), if_pc, vecs[i].e_ifpc);
            chk($sformatf("vec%0d.if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("vec%0d.pc_fault", i), {31'd0, pc_fault}, {31'd0, vecs[i].e_fault});
            chk($sformatf("vec%0d.halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halt});
            $display("vec %0d: imem_pc=%h if_pc=%h if_valid=%0d pc_fault=%0d halted=%0d",
                     i, imem_pc, if_pc, if_valid, pc_fault, halted);
        end

        // Window end: sequential fetch past the last word must fault, not wrap.
        cycle(0, 0, 1, 32'h3FF8, 0);
        cycle(0, 0, 0, 32'h0, 0);
        chk("end.imem_pc", imem_pc, 32'h3FFC);
        cycle(0, 0, 0, 32'h0, 0);
        chk("end.fault_pc_held", imem_pc, 32'h3FFC);
        chk("end.if_pc_latched", if_pc, 32'h3FFC);
        chk("end.if_instr_latched", if_instr, mem[1023]);
        chk("end.if_valid", {31'd0, if_valid}, 32'd0);
        chk("end.pc_fault", {31'd0, pc_fault}, 32'd1);
        $display("window end: imem_pc=%h if_pc=%h pc_fault=%0d", imem_pc, if_pc, pc_fault);
        cycle(1, 0, 0, 32'h0, 0);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < 100; i++) begin
                logic [31:0] rpc;
                int          kind;
                kind = int'($urandom_range(0, 7));
                rpc  = 32'h3000 + ($urandom_range(0, 1023) * 4);
                if (kind == 0) rpc = rpc + $urandom_range(1, 3);
                else if (kind == 1) rpc = ($urandom_range(0, 1) != 0) ? 32'h2FFC : rpc + 32'h1000;
                cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0, rpc, $urandom_range(0, 63) == 0);
            end
            $display("random block %0d: imem_pc=%h errors=%0d", blk, imem_pc, errors);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage that drives the instruction memory's PC input and captures the returned word into the IF/ID pipeline register. Owns the architectural PC: reset vector, sequential +4, branch/jump redirect, stall hold, halt, and range/alignment fault detection. Sits directly upstream of the combinational-read instruction memory (text base 0x3000, 4 KB) and feeds the decode stage.

Parameters:
RESET_PC, 32'h0000_3000, reset vector and base of instruction memory window
INSTR_MEM_BYTES, 'h1000, size of instruction window in bytes; valid PCs are [RESET_PC, RESET_PC+INSTR_MEM_BYTES)

Ports:
clock  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-high
stall  input  1  decode/hazard unit requests hold of PC and IF/ID register
redirect_valid  input  1  taken branch/jump this cycle
redirect_pc  input  32  target address for redirect
halt  input  1  stop fetching (e.g. exit syscall retired)
imem_pc  output  32  PC presented to instruction memory
imem_instr  input  32  instruction word returned combinationally by memory
if_instr  output  32  registered instruction to decode
if_pc  output  32  registered PC of if_instr
if_pc_plus4  output  32  registered if_pc + 4
if_valid  output  1  if_instr is a real instruction (0 = bubble)
pc_fault  output  1  sticky: misaligned or out-of-window PC encountered
halted  output  1  fetch FSM is in HALTED

Behaviour:
- Reset (sync, active-high, wins over everything): pc <= RESET_PC; if_instr, if_pc, if_pc_plus4 <= 0; if_valid <= 0; pc_fault <= 0; FSM <= RUN. Reset mid-stall/mid-redirect discards the pending action.
- imem_pc = pc register (no combinational path from inputs). Memory read is combinational, so fetch latency = 1 cycle: word at pc appears in if_instr on the next edge.
- FSM states RUN, HALTED, FAULT. Per-edge priority in RUN: halt > redirect_valid > stall > sequential.
- RUN, sequential (no stall/redirect/halt): if_instr <= imem_instr; if_pc <= pc; if_pc_plus4 <= pc+4; if_valid <= 1; pc <= pc+4.
- RUN, stall only: pc and all if_* registers hold.
- RUN, redirect_valid (with or without stall): pc <= redirect_pc; if_valid <= 0 (wrong-path word squashed); other if_* registers hold. Redirect overrides stall.
- RUN, halt: FSM -> HALTED; if_valid <= 0; pc holds. HALTED exits only on reset; inputs ignored.
- Fault check on the next-PC value (pc+4 or redirect_pc): if bits[1:0] != 0 or outside [RESET_PC, RESET_PC+INSTR_MEM_BYTES): pc is NOT updated, pc_fault <= 1, FSM -> FAULT, if_valid <= 0. The current good instruction is still latched (sequential case). FAULT exits only on reset.
- Wrap-around: pc+4 from last word (RESET_PC+INSTR_MEM_BYTES-4) is out of window -> FAULT; no wrap to base. 32-bit add, carry discarded.
- halted = (FSM == HALTED); pc_fault sticky until reset.

Optional Feature:
BRANCH_DELAY_SLOT_EN. Defined: MIPS delay slot honoured; on redirect_valid without stall, the word currently at pc is latched with if_valid <= 1 (it is the slot instruction), then pc <= redirect_pc. With stall, redirect is held off until stall deasserts (redirect_valid must be held by the source). Undefined: redirect squashes the in-flight word (if_valid <= 0) as described above.

Decomposition:
- Shared package: RESET_PC and INSTR_MEM_BYTES defaults, NOP encoding 32'h0, FSM state encoding (RUN=2'd0, HALTED=2'd1, FAULT=2'd2), instruction width 32.
- One natural sub-module: if_id_reg (IF/ID pipeline register with load/hold/flush controls), instantiated once; PC/FSM logic stays in instr_fetch.

Test Plan:
- Reset then 3 free-running cycles -> imem_pc 0x3000,0x3004,0x3008; if_pc 0x3000,0x3004 with if_valid=1, if_pc_plus4 = if_pc+4.
- stall held 2 cycles at pc=0x3008 -> imem_pc stays 0x3008, if_instr/if_pc unchanged, resumes at 0x300C after release.
- redirect_valid=1, redirect_pc=0x3100 at pc=0x3010 -> next imem_pc=0x3100, if_valid=0 one cycle (macro off) / if_pc=0x3010 valid (macro on).
- redirect_pc=0x3102 -> pc_fault=1, FSM FAULT, imem_pc held; same for redirect_pc=0x4000 and sequential from 0x3FFC.
- halt=1 with simultaneous redirect -> halted=1, pc unchanged, if_valid=0; stays halted until reset.
- reset asserted while stall=1 and redirect_valid=1 -> next cycle pc=0x3000, all if_* zero, pc_fault=0.
